// File: rtl/mdu_defs.sv
// mdu_defs: shared op_E encodings, default latencies and op classification helpers
package mdu_defs;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;
    function automatic logic isMulDiv(input logic [2:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
    endfunction
    function automatic logic isDiv(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit mul/div result {hi, lo} for op, rs, rt
//   op     : op_E encoding from mdu_defs
//   rs, rt : operands
//   result : MULT/MULTU product, or DIV/DIVU {remainder, quotient}; 0 otherwise
module mdu_arith
    import mdu_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result
);
    logic signed [63:0] mulS;
    logic [63:0] mulU;
    logic [31:0] divisor, quotS, remS, quotU, remU;
    // A zero divisor is replaced by 1 so the datapath never produces X; the
    // scheduler discards that result via its no-commit flag anyway.
    assign divisor = (rt == 32'd0) ? 32'd1 : rt;
    assign mulS  = $signed(rs) * $signed(rt);
    assign mulU  = {32'd0, rs} * {32'd0, rt};
    assign quotS = $signed(rs) / $signed(divisor);
    assign remS  = $signed(rs) % $signed(divisor);
    assign quotU = rs / divisor;
    assign remU  = rs % divisor;
    always_comb
        result = (op == OP_MULT)  ? mulS :
                 (op == OP_MULTU) ? mulU :
                 (op == OP_DIV)   ? {remS, quotS} :
                 (op == OP_DIVU)  ? {remU, quotU} : 64'd0;
endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multi-cycle MDU sequencing with pending HI/LO buffer and D-stage stall
//   clk, reset        : clock, synchronous active-high reset
//   start_E, op_E     : E-stage MDU operation and its encoding
//   rs_E, rt_E        : forwarded operands
//   flush_E           : E-stage instruction cancelled this cycle
//   mdu_use_D         : D-stage instruction touches the MDU
//   busy, stall_D     : operation in flight, freeze request for F/D
//   hi, lo            : architectural HI/LO
module mdu_scheduler
    import mdu_defs::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        flush_E,
    input  logic        mdu_use_D,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0] state;
    logic [CW-1:0] count;
    logic [31:0] pHi, pLo;
    logic noCommit, accept, issue;
    logic [63:0] arithResult;
    mdu_arith arith (.op(op_E), .rs(rs_E), .rt(rt_E), .result(arithResult));
    assign accept  = start_E & ~flush_E & ~busy;
    assign issue   = accept & isMulDiv(op_E);
    // state mirrors count != 0 but is its own flop so busy comes straight from a register
    assign busy    = (state == RUN);
    assign stall_D = mdu_use_D & (busy | (start_E & ~flush_E & isMulDiv(op_E)));
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            noCommit <= 1'b0;
            pHi      <= '0;
            pLo      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (issue) begin
            state    <= RUN;
            count    <= isDiv(op_E) ? CW'(DIV_LAT) : CW'(MULT_LAT);
            noCommit <= isDiv(op_E) && rt_E == 32'd0;
            {pHi, pLo} <= arithResult;
        end else if (state == RUN) begin
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                state <= IDLE;
                if (!noCommit) {hi, lo} <= {pHi, pLo};
            end
        end else if (accept) begin
            // moves only reach here while idle, so they never race a completion
            if (op_E == OP_MTHI) hi <= rs_E;
            if (op_E == OP_MTLO) lo <= rs_E;
        end
    end
endmodule
